// File: rtl/ibex_register_file_cache.sv
// ibex_register_file_cache: fully-associative read cache over a flop backing file, write-through, serial miss fills.
// Define IBEX_RFC_PERF_CNT_EN to add the hit_cnt_o/miss_cnt_o lookup counters.
module ibex_register_file_cache #(
  parameter bit          RV32E         = 1'b0,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned CacheEntries  = 4,
  parameter int unsigned NumReadPorts  = 2,
  parameter int unsigned MissLatency   = 2,
  parameter bit          WriteAllocate = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReadPorts-1:0]           rreq_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  output logic [NumReadPorts-1:0]           rvalid_o,
  input  logic                              we_i,
  input  logic [4:0]                        waddr_i,
  input  logic [DataWidth-1:0]              wdata_i,
  input  logic                              flush_i,
  output logic                              stall_o
`ifdef IBEX_RFC_PERF_CNT_EN
  ,
  output logic [31:0]                       hit_cnt_o,
  output logic [31:0]                       miss_cnt_o
`endif
);
  localparam int AW = RV32E ? 4 : 5;
  localparam int NR = 2 ** AW;
  localparam int CW = $clog2(MissLatency + 1);
  localparam int EW = $clog2(CacheEntries);
  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_e;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          maddr_q, maddr_d, mreq;
  logic [EW-1:0]          vptr_q, vptr_d, wvic, fvic, p2;
  logic [CacheEntries-1:0] valid_q, valid_d, v2, wm, fm;
  logic [AW-1:0]          tag_q [CacheEntries];
  logic [AW-1:0]          tag_d [CacheEntries];
  logic [DataWidth-1:0]   data_q [CacheEntries];
  logic [DataWidth-1:0]   data_d [CacheEntries];
  logic [DataWidth-1:0]   rf_q [NR];
  logic [NumReadPorts-1:0] hit, miss;
  logic [EW:0]            wv, fv;
  logic [AW-1:0]          wa;
  logic                   wen, walloc, do_fill, ok;
  function automatic logic [EW:0] first_free(input logic [CacheEntries-1:0] v);
    first_free = '0;
    for (int e = CacheEntries - 1; e >= 0; e--) if (!v[e]) first_free = {1'b1, EW'(e)};
  endfunction
  function automatic logic [EW-1:0] nxt(input logic [EW-1:0] p);
    return p == EW'(CacheEntries - 1) ? '0 : p + EW'(1);
  endfunction
  assign ok = !rst_i && state_q == IDLE && !(|miss);
  for (genvar p = 0; p < NumReadPorts; p++) begin : g_port
    logic [AW-1:0]           a;
    logic [CacheEntries-1:0] m;
    logic [DataWidth-1:0]    d;
    assign a = raddr_i[p*5 +: AW];
    always_comb begin
      m = '0;
      d = '0;
      for (int e = 0; e < CacheEntries; e++) begin
        m[e] = valid_q[e] && tag_q[e] == a;
        d = d | (m[e] ? data_q[e] : '0);
      end
    end
    assign hit[p] = a == '0 || |m;
    assign miss[p] = rreq_i[p] && !hit[p];
    assign rvalid_o[p] = rreq_i[p] && hit[p] && ok;
    assign rdata_o[p*DataWidth +: DataWidth] = rvalid_o[p] ? d : '0;
  end
  assign stall_o = !rst_i && (state_q != IDLE || |miss);
  assign wa = waddr_i[AW-1:0];
  assign wen = we_i && wa != '0;
  always_comb begin
    mreq = '0;
    wm = '0;
    fm = '0;
    for (int p = NumReadPorts - 1; p >= 0; p--) if (miss[p]) mreq = raddr_i[p*5 +: AW];
    for (int e = 0; e < CacheEntries; e++) begin
      wm[e] = valid_q[e] && tag_q[e] == wa;
      fm[e] = valid_q[e] && tag_q[e] == maddr_q;
    end
  end
  assign walloc = WriteAllocate && wen && !(|wm) && !flush_i;
  // A fill is dropped if its address is already cached or is being write-allocated now.
  assign do_fill = state_q == FILL && !flush_i && !(|fm) && !(walloc && wa == maddr_q);
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    wv = first_free(valid_q);
    wvic = wv[EW] ? wv[EW-1:0] : vptr_q;
    v2 = valid_q;
    p2 = vptr_q;
    for (int e = 0; e < CacheEntries; e++) if (wm[e] && wen && !flush_i) data_d[e] = wdata_i;
    if (walloc) begin
      valid_d[wvic] = 1'b1;
      tag_d[wvic] = wa;
      data_d[wvic] = wdata_i;
      v2[wvic] = 1'b1;
      p2 = wv[EW] ? vptr_q : nxt(vptr_q);
    end
    fv = first_free(v2);
    fvic = fv[EW] ? fv[EW-1:0] : p2;
    if (do_fill) begin
      valid_d[fvic] = 1'b1;
      tag_d[fvic] = maddr_q;
      data_d[fvic] = rf_q[maddr_q];
      p2 = fv[EW] ? p2 : nxt(p2);
    end
    vptr_d = p2;
    if (flush_i) valid_d = '0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    maddr_d = maddr_q;
    case (state_q)
      IDLE: if (|miss) begin
        state_d = FETCH;
        maddr_d = mreq;
        cnt_d = CW'(MissLatency - 1);
      end
      FETCH: begin
        state_d = cnt_q == '0 ? FILL : FETCH;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      maddr_q <= '0;
      vptr_q <= '0;
      valid_q <= '0;
      for (int e = 0; e < CacheEntries; e++) begin
        tag_q[e] <= '0;
        data_q[e] <= '0;
      end
      for (int r = 0; r < NR; r++) rf_q[r] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      maddr_q <= maddr_d;
      vptr_q <= vptr_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      data_q <= data_d;
      if (wen) rf_q[wa] <= wdata_i;
    end
  end
`ifdef IBEX_RFC_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else if (state_q == IDLE) begin
      hit_cnt_o <= hit_cnt_o + 32'($countones(rreq_i & hit));
      miss_cnt_o <= miss_cnt_o + 32'($countones(miss));
    end
  end
`endif
endmodule
